fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares one floating-point adder among up to NUM_REQ requesters (angle combination, state-update and similar sequencers) using the same start-pulse / ready-pulse handshake each requester would use with a dedicated adder. Each requester's operands are latched on its start pulse. Requests are granted round-robin, and the sum plus a one-cycle ready pulse are returned to the originating requester only. The block sits between the requester FSMs and the single adder instance in the datapath.

## Interface
Parameters:
- EXP_LEN, 8, exponent width
- MANTISSA_LEN, 23, mantissa width; word width W = EXP_LEN+MANTISSA_LEN+1
- NUM_REQ, 4, number of requesters (2..16)
- TIMEOUT_CYCLES, 64, watchdog limit (used only with FP_ARB_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_add_start  in  1 x [NUM_REQ]  per-requester one-cycle start pulse
- req_add_a / req_add_b  in  W x [NUM_REQ]  operands, valid in the start cycle
- req_add_sum  out  W x [NUM_REQ]  last sum returned to that requester
- req_add_ready  out  1 x [NUM_REQ]  one-cycle result pulse
- add_start  out  1  start pulse to the adder
- add_a / add_b  out  W  adder operands
- add_sum  in  W  adder result
- add_ready  in  1  adder result pulse
- busy  out  1  high while any request is pending or in flight
- err_overrun  out  NUM_REQ  sticky; start received while that requester was already pending or in flight
- err_timeout  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- Per-requester pending bit and operand latch. On req_add_start[i] with pending[i]=0, the block latches a and b and sets pending[i] on that edge. If pending[i]=1 (queued or in flight), the start is dropped and err_overrun[i] is set.
- Round-robin pointer last_grant, reset to NUM_REQ-1 so requester 0 wins first. The search starts at last_grant+1 mod NUM_REQ. The first pending requester wins; last_grant updates to the winner at grant.
- FSM states:
  - IDLE: if any pending bit is set, register grant g, drive add_a/add_b from latch[g], set add_start<=1, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: add_start<=0. On add_ready: req_add_sum[g]<=add_sum, req_add_ready[g]<=1, pending[g]<=0, go to RETURN.
  - RETURN: req_add_ready<=0, go to IDLE.
  - Any undefined encoding returns to IDLE.
- add_ready outside WAIT is ignored.
- A start for the granted requester in the same cycle its add_ready arrives is dropped, because pending[g] is still 1. This sets err_overrun[g].
- req_add_sum[i] holds its value until the next result for requester i.
- busy = any pending bit set, or state != IDLE.
- Error flags clear only on reset.

## Timing
- Reset values:
  - add_start, req_add_ready, busy, err_overrun, err_timeout, pending: 0
  - add_a, add_b, req_add_sum: 0
  - state IDLE; last_grant NUM_REQ-1
- Reset mid-operation discards all pending and in-flight requests. A late add_ready after reset is ignored because the state is IDLE.
- Start in cycle 0: pending visible in cycle 1. add_start is high in cycle 2 only. If add_ready arrives in cycle k, req_add_ready is high in cycle k+1.
- Uncontended overhead is 3 cycles plus adder latency. Back-to-back grants are separated by at least one IDLE cycle after RETURN.
- Simultaneous starts from all requesters are all latched in the same cycle. They are served in round-robin order.

## Configuration
- FP_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without add_ready, the block sets err_timeout.
  - It then returns req_add_sum[g]=0 with req_add_ready[g] pulsed, clears pending[g], and goes to RETURN.
  - A stale add_ready arriving later is ignored.
- FP_ARB_TIMEOUT_EN undefined: no counter; err_timeout is tied 0; WAIT waits indefinitely.

## Test plan
- Single request: adder model with 4-cycle latency; req 2 starts with a=0x3F800000, b=0x40000000. Required: add_start in cycle 2 with those operands; req_add_ready[2] pulses once with sum 0x40400000; other ready bits stay 0; busy falls after RETURN.
- Contention: all 4 requesters start in the same cycle with distinct operands. Required: grant order 0,1,2,3; each req_add_ready[i] carries its own sum; grants are separated by at least one IDLE cycle.
- Fairness: requesters 0 and 1 re-request immediately after each ready for 10 operations. Required: strict alternation 0,1,0,1…
- Overrun: req 1 starts, then starts again 2 cycles later. Required: the second start is dropped; err_overrun=0b0010; exactly one result is returned, using the first operands.
- Reset mid-WAIT: assert reset while the adder is busy, then fire add_ready 2 cycles later. Required: no req_add_ready pulse; all outputs at reset values.
- With FP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: the adder never responds. Required: err_timeout=1, req_add_ready[g] pulses with sum 0, and the next pending requester is granted.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one floating-point adder among NUM_REQ start/ready requesters.
// Optional watchdog on the adder response is enabled by defining FP_ARB_TIMEOUT_EN.
module fp_add_arbiter #(
  parameter int EXP_LEN        = 8,
  parameter int MANTISSA_LEN   = 23,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W             = EXP_LEN + MANTISSA_LEN + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_add_start,
  input  logic [NUM_REQ-1:0][W-1:0]     req_add_a,
  input  logic [NUM_REQ-1:0][W-1:0]     req_add_b,
  output logic [NUM_REQ-1:0][W-1:0]     req_add_sum,
  output logic [NUM_REQ-1:0]            req_add_ready,
  output logic                          add_start,
  output logic [W-1:0]                  add_a,
  output logic [W-1:0]                  add_b,
  input  logic [W-1:0]                  add_sum,
  input  logic                          add_ready,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            err_overrun,
  output logic                          err_timeout
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RET  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               last_grant_q, last_grant_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [NUM_REQ-1:0]          pending_q, pending_d;
  logic [NUM_REQ-1:0][W-1:0]   lat_a_q, lat_a_d;
  logic [NUM_REQ-1:0][W-1:0]   lat_b_q, lat_b_d;
  logic [NUM_REQ-1:0][W-1:0]   sum_q, sum_d;
  logic [NUM_REQ-1:0]          ready_q, ready_d;
  logic [NUM_REQ-1:0]          overrun_q, overrun_d;
  logic                        add_start_q, add_start_d;
  logic [W-1:0]                add_a_q, add_a_d;
  logic [W-1:0]                add_b_q, add_b_d;

  logic                        hi_found, lo_found, win_found;
  logic [GW-1:0]               hi_idx, lo_idx, win_idx;
  logic                        timeout_hit;
  logic                        result_fire;
  logic [W-1:0]                result_value;

  // Round-robin search: the lowest pending index above last_grant wins, else wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if (GW'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = GW'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // A timeout completes the transaction with a zero sum; a real response takes precedence.
  assign result_fire  = (state_q == S_WAIT) & (add_ready | timeout_hit);
  assign result_value = add_ready ? add_sum : '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic accept;
      logic mine_done;

      assign accept          = req_add_start[gi] & ~pending_q[gi];
      assign mine_done       = result_fire & (grant_q == GW'(gi));
      assign pending_d[gi]   = accept | (pending_q[gi] & ~mine_done);
      assign lat_a_d[gi]     = accept ? req_add_a[gi] : lat_a_q[gi];
      assign lat_b_d[gi]     = accept ? req_add_b[gi] : lat_b_q[gi];
      assign overrun_d[gi]   = overrun_q[gi] | (req_add_start[gi] & pending_q[gi]);
      assign sum_d[gi]       = mine_done ? result_value : sum_q[gi];
      assign ready_d[gi]     = mine_done;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_WAIT;
      S_WAIT:  if (result_fire) state_d = S_RET;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    add_start_d  = 1'b0;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (state_q == S_IDLE && win_found) begin
      add_start_d  = 1'b1;
      add_a_d      = lat_a_q[win_idx];
      add_b_d      = lat_b_q[win_idx];
      grant_d      = win_idx;
      last_grant_d = win_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      pending_q    <= '0;
      lat_a_q      <= '0;
      lat_b_q      <= '0;
      sum_q        <= '0;
      ready_q      <= '0;
      overrun_q    <= '0;
      add_start_q  <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      pending_q    <= pending_d;
      lat_a_q      <= lat_a_d;
      lat_b_q      <= lat_b_d;
      sum_q        <= sum_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      add_start_q  <= add_start_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
    end
  end

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_to_q, err_to_d;

  // The counter holds the number of WAIT cycles already spent; it restarts at every grant.
  assign timeout_hit = (state_q == S_WAIT) & ~add_ready & (wcnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign wcnt_d      = (state_q == S_WAIT) ? wcnt_q + 1'b1 : '0;
  assign err_to_d    = err_to_q | timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign timeout_hit = 1'b0;
  // Constant low: TIMEOUT_CYCLES is never negative.
  assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign req_add_sum   = sum_q;
  assign req_add_ready = ready_q;
  assign add_start     = add_start_q;
  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign err_overrun   = overrun_q;
  assign busy          = (|pending_q) | (state_q != S_IDLE);

endmodule
